// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus register-file/ALU control bus for regfile_sequencer.
// The master issues instructions; the slave (sequencer) drives the control outputs.
interface regfile_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  DA;
  logic [3:0]  AA;
  logic [3:0]  BA;
  logic        RW;
  logic [3:0]  FS;
  logic        MB;
  logic [15:0] imm;
  logic        done;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    output instr, instr_valid,
    input  instr_ready, DA, AA, BA, RW, FS, MB, imm, done, illegal, retired
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, DA, AA, BA, RW, FS, MB, imm, done, illegal, retired
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Four-state instruction sequencer (IDLE/DECODE/EXEC/WB) driving register-file and ALU controls.
// All outputs registered; RW/done appear three cycles after acceptance, issue interval 4 cycles.
module regfile_sequencer (
  input  logic               clk,
  input  logic               clr,
  regfile_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  typedef struct packed {
    logic [3:0]  da;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [3:0]  fs;
    logic        mb;
    logic [15:0] imm;
  } dec_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  dec_t        dec_q, dec_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        ready_q, ready_d;
  logic [15:0] retired_q, retired_d;
  logic        ir_legal;

  // Illegal opcodes still present their raw address fields, with FS/MB/imm zeroed.
  function automatic dec_t decode(input logic [15:0] w);
    dec_t d;
    d.da  = w[11:8];
    d.aa  = w[7:4];
    d.ba  = w[3:0];
    d.fs  = 4'd0;
    d.mb  = 1'b0;
    d.imm = 16'd0;
    case (w[15:12])
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: d.fs = w[15:12];
      4'd7: begin
        d.fs  = 4'd1;
        d.mb  = 1'b1;
        d.imm = {12'd0, w[3:0]};
      end
      4'd8: begin
        d.fs  = 4'd7;
        d.mb  = 1'b1;
        d.imm = {8'd0, w[7:0]};
        d.aa  = 4'd0;
        d.ba  = 4'd0;
      end
      default: ;
    endcase
    return d;
  endfunction

  assign ir_legal = (ir_q[15:12] <= 4'd8);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.instr_valid) state_d = DECODE;
      DECODE:  state_d = ir_legal ? EXEC : IDLE;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the state being left, so RW/done land one cycle after WB.
  always_comb begin
    ir_d      = ir_q;
    dec_d     = dec_q;
    rw_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    retired_d = retired_q;
    ready_d   = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          ir_d  = bus.instr;
          dec_d = decode(bus.instr);
        end
      end
      DECODE: begin
        dec_d     = decode(ir_q);
        illegal_d = !ir_legal;
      end
      WB: begin
        rw_d      = (ir_q[15:12] != 4'd0);
        done_d    = 1'b1;
        retired_d = retired_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir_q      <= 16'd0;
      dec_q     <= '0;
      rw_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
      retired_q <= 16'd0;
    end else begin
      ir_q      <= ir_d;
      dec_q     <= dec_d;
      rw_q      <= rw_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
      retired_q <= retired_d;
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.DA          = dec_q.da;
  assign bus.AA          = dec_q.aa;
  assign bus.BA          = dec_q.ba;
  assign bus.FS          = dec_q.fs;
  assign bus.MB          = dec_q.mb;
  assign bus.imm         = dec_q.imm;
  assign bus.RW          = rw_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, clr.
REQ-002 The port list SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- clr  in  1  async active-high reset
- instr  in  16  instruction word: [15:12] opcode, [11:8] dest, [7:4] srcA, [3:0] srcB/imm4
- instr_valid  in  1  instr is offered this cycle
- instr_ready  out  1  sequencer can accept an instruction
- DA  out  4  register-file destination address
- AA  out  4  register-file read address A
- BA  out  4  register-file read address B
- RW  out  1  register-file write enable
- FS  out  4  ALU function select
- MB  out  1  1 = B operand from imm, 0 = from register B
- imm  out  16  immediate operand
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse when an opcode is rejected
- retired  out  16  count of retired instructions
REQ-003 All outputs SHALL be registered.

Function
REQ-004 FSM states SHALL be IDLE, DECODE, EXEC and WB.
REQ-005 instr_ready SHALL be 1 only in IDLE.
REQ-006 Handshake: in IDLE, when instr_valid=1, instr SHALL be latched into an internal IR and the FSM SHALL go to DECODE; if instr_valid=0, the FSM SHALL stay in IDLE.
REQ-007 DECODE SHALL drive DA, AA, BA, FS, MB and imm from IR and SHALL hold them stable through EXEC and WB; RW SHALL be 0.
REQ-008 Opcode map (FS / MB / imm):
- 0 NOP: FS=0; no write
- 1 ADD: FS=1
- 2 SUB: FS=2
- 3 AND: FS=3
- 4 OR: FS=4
- 5 XOR: FS=5
- 6 MOV: FS=6 (pass A)
- 7 ADDI: FS=1, MB=1, imm = zero-extended IR[3:0]
- 8 LDI: FS=7 (pass B), MB=1, imm = zero-extended IR[7:0], AA=BA=0
- MB SHALL be 0 and imm SHALL be 0 for every opcode except 7 and 8.
REQ-009 Opcodes 9-15 SHALL be illegal: from DECODE the FSM SHALL return to IDLE, pulse illegal for 1 cycle, keep RW=0, and leave retired unchanged.
REQ-010 The FSM SHALL go from DECODE (legal opcode) to EXEC, which lasts one cycle for operand/ALU settling with RW=0.
REQ-011 WB SHALL last exactly one cycle: RW=1 for opcodes 1-8 and RW=0 for NOP; done=1; retired increments by 1; the next state is IDLE.
REQ-012 Latency: with the handshake accepted at edge N, RW/done SHALL be asserted during the cycle after edge N+3. Minimum issue interval SHALL be 4 cycles.
REQ-013 retired SHALL wrap from 0xFFFF to 0x0000.
REQ-014 RW SHALL never be 1 outside WB, and never for more than 1 consecutive cycle.
REQ-015 instr_valid asserted outside IDLE SHALL be ignored, with no latch and no side effect.
REQ-016 Dest=0 SHALL be writable; there is no hard-wired zero register.

Reset
REQ-017 On clr=1, the block SHALL immediately (asynchronously) go to state IDLE with IR=0 and DA=AA=BA=0, FS=0, MB=0, imm=0, RW=0, done=0, illegal=0 and retired=0; instr_ready=1 while clr=0 and in IDLE.
REQ-018 clr asserted mid-instruction (DECODE/EXEC/WB) SHALL abort it: no RW pulse, no done, and the count is not incremented.
REQ-019 The first handshake SHALL be accepted at the first rising edge with clr=0 and instr_valid=1.

Verification
REQ-020 ADD: instr=0x1234 accepted -> DECODE shows DA=2, AA=3, BA=4, FS=1, MB=0; 3 cycles later RW=1 and done=1 for 1 cycle; retired=1.
REQ-021 LDI: instr=0x85A7 -> DA=5, MB=1, imm=0x00A7, FS=7, RW=1 in WB; ADDI instr=0x71 2F -> imm=0x000F, FS=1.
REQ-022 Illegal: instr=0xC123 -> illegal pulse 1 cycle after DECODE, RW never 1, retired unchanged, instr_ready=1 again.
REQ-023 Back-to-back: instr_valid held high with 3 instructions -> accepted exactly every 4 cycles, 3 RW pulses, retired=3; NOP retires with done=1 and RW=0.
REQ-024 Reset: clr pulsed during EXEC of 0x1234 -> outputs immediately at reset values, no RW pulse; next instruction executes normally.
REQ-025 Wrap: preload via 65535 NOPs (or force) -> the next retire gives retired=0x0000.
